// File: rtl/pll_lock_monitor.sv
// Phase-frequency detector and lock monitor for the PLL feedback loop.
// Compares ref_clk against the divided feedback clock fb, sampled on the fast clock clk.
module pll_lock_monitor #(
  parameter int WINDOW       = 64,
  parameter int CW           = 8,
  parameter int TOL          = 1,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ref_clk,   // reference clock; "ref" is a reserved word
  input  logic          fb,
  output logic          up,
  output logic          dn,
  output logic          lock,
  output logic [CW:0]   freq_err,
  output logic          err_valid,
  output logic [1:0]    pfd_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } pfd_t;

  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CW-1:0]        CNT_MAX   = '1;
  localparam logic [CW-1:0]        LAST_REF  = CW'(WINDOW - 1);
  localparam logic signed [CW:0]   WINDOW_S  = (CW+1)'(WINDOW);
  localparam logic signed [CW:0]   TOL_S     = (CW+1)'(TOL);
  localparam logic [GW-1:0]        LOCK_GOOD = GW'(LOCK_WINDOWS);

  pfd_t state, state_next;

  logic [2:0]          ref_sync, fb_sync;
  logic                ref_edge, fb_edge;
  logic [CW-1:0]       ref_cnt, fb_cnt, fb_total;
  logic signed [CW:0]  err_new;
  logic                win_close, err_good;
  logic [GW-1:0]       good_cnt, good_next;

  // Bit 0 is the first sync stage; a rising edge is seen between stages 2 and 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_clk};
      fb_sync  <= {fb_sync[1:0], fb};
    end
  end

  assign ref_edge  = ref_sync[1] & ~ref_sync[2];
  assign fb_edge   = fb_sync[1] & ~fb_sync[2];
  assign pfd_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ref_edge && !fb_edge)      state_next = UP;
        else if (fb_edge && !ref_edge) state_next = DN;
      end
      UP:      if (fb_edge && !ref_edge) state_next = IDLE;
      DN:      if (ref_edge && !fb_edge) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // up/dn are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      up    <= 1'b0;
      dn    <= 1'b0;
    end else begin
      state <= state_next;
      up    <= (state_next == UP);
      dn    <= (state_next == DN);
    end
  end

  always_comb begin
    win_close = ref_edge && (ref_cnt == LAST_REF);
    fb_total  = (fb_edge && (fb_cnt != CNT_MAX)) ? fb_cnt + 1'b1 : fb_cnt;
    err_new   = $signed({1'b0, fb_total}) - WINDOW_S;
    err_good  = (err_new <= TOL_S) && (err_new >= -TOL_S);
    good_next = '0;
    if (err_good) good_next = (good_cnt == LOCK_GOOD) ? good_cnt : good_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt   <= '0;
      fb_cnt    <= '0;
      good_cnt  <= '0;
      freq_err  <= '0;
      err_valid <= 1'b0;
      lock      <= 1'b0;
    end else if (win_close) begin
      freq_err  <= err_new;
      err_valid <= 1'b1;
      ref_cnt   <= '0;
      fb_cnt    <= '0;
      good_cnt  <= good_next;
      lock      <= (good_next == LOCK_GOOD);
    end else begin
      err_valid <= 1'b0;
      if (ref_edge) ref_cnt <= ref_cnt + 1'b1;
      if (fb_edge && (fb_cnt != CNT_MAX)) fb_cnt <= fb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: cycle-aligned ref/fb waveforms, an edge-counting
// reference model feeding an expected queue, and a monitor scoring err_valid events.
module tb_pll_lock_monitor;

  localparam int WINDOW = 64;
  localparam int CW     = 8;
  localparam int TOL    = 1;
  localparam int LOCKW  = 4;
  localparam int RP     = 20;             // ref period in clk cycles
  localparam int WCYC   = WINDOW * RP;    // clk cycles per measurement window

  logic          clk, rst, ref_clk, fb;
  logic          up, dn, lock, err_valid;
  logic [CW:0]   freq_err;
  logic [1:0]    pfd_state;

  pll_lock_monitor #(.WINDOW(WINDOW), .CW(CW), .TOL(TOL), .LOCK_WINDOWS(LOCKW)) dut (
    .clk(clk), .rst(rst), .ref_clk(ref_clk), .fb(fb),
    .up(up), .dn(dn), .lock(lock), .freq_err(freq_err),
    .err_valid(err_valid), .pfd_state(pfd_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [CW+1:0] exp_q[$];   // {lock, freq_err}

  // stimulus state
  int   t = 0;
  logic ref_en = 1'b0;
  int   fb_mode = 0;   // 0 off, 1 ref shifted by fb_lag, 2 own period fb_per
  int   fb_lag = 0;
  int   fb_per = 10;
  int   inj_left = 0;

  // reference model state
  int   rc = 0, fbc = 0, streak = 0;
  logic m_lock = 1'b0;
  logic pr = 1'b0, pf = 1'b0;

  // pulse expectations: -1 unchecked, 0 forbidden, >0 expected width +-1
  int up_exp = -1, dn_exp = -1;
  int up_w = 0, dn_w = 0, up_cnt = 0, dn_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic fb_level(input int tt);
    logic v;
    v = 1'b0;
    case (fb_mode)
      1:       v = ((tt - fb_lag + 2 * RP) % RP) < (RP / 2);
      2:       v = (tt % fb_per) < (fb_per / 2);
      default: v = 1'b0;
    endcase
    if (inj_left > 0 && (tt % RP) >= 12 && (tt % RP) < 14) v = 1'b1;
    return v;
  endfunction

  // One window closes on every WINDOW-th ref rise; fb rises in that same cycle count.
  task automatic model_step(input logic r, input logic f);
    int tot, err;
    logic [CW+1:0] e;
    if (f && !pf) fbc++;
    if (r && !pr) begin
      rc++;
      if (rc == WINDOW) begin
        tot = (fbc > (1 << CW) - 1) ? (1 << CW) - 1 : fbc;
        err = tot - WINDOW;
        if (err >= -TOL && err <= TOL) streak++;
        else streak = 0;
        m_lock = (streak >= LOCKW);
        e[CW:0]   = err[CW:0];
        e[CW+1]   = m_lock;
        exp_q.push_back(e);
        rc  = 0;
        fbc = 0;
      end
    end
    pr = r;
    pf = f;
  endtask

  task automatic drive(input int n);
    logic r, f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r = ref_en && ((t % RP) < (RP / 2));
      f = fb_level(t);
      ref_clk = r;
      fb      = f;
      model_step(r, f);
      if (inj_left > 0 && (t % RP) == 13) inj_left--;
      t++;
    end
  endtask

  task automatic align();
    drive((RP - (t % RP)) % RP);
  endtask

  task automatic apply_reset();
    ref_clk = 1'b0;
    fb      = 1'b0;
    rst     = 1'b0;
    exp_q.delete();
    rc = 0; fbc = 0; streak = 0; m_lock = 1'b0; pr = 1'b0; pf = 1'b0;
    up_exp = -1; dn_exp = -1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_up"}, int'(up), 0);
    check({name, "_dn"}, int'(dn), 0);
    check({name, "_lock"}, int'(lock), 0);
    check({name, "_err_valid"}, int'(err_valid), 0);
    check({name, "_freq_err"}, int'(freq_err), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   prev_ev = 0;
  logic have_prev = 1'b0;
  logic both_seen = 1'b0, lock_glitch = 1'b0, lock_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 1'b0; up_w = 0; dn_w = 0;
      both_seen = 1'b0; lock_glitch = 1'b0; lock_prev = 1'b0;
    end else begin
      if (up && dn) both_seen = 1'b1;
      if (lock != lock_prev && !err_valid) lock_glitch = 1'b1;
      lock_prev = lock;
      if (up) up_w++;
      else if (up_w > 0) begin
        up_cnt++;
        if (up_exp >= 0) begin
          tests++;
          if (up_exp == 0 || up_w < up_exp - 1 || up_w > up_exp + 1) begin
            fails++;
            $display("FAIL up_width: got %0d expected %0d (0 = no pulse)", up_w, up_exp);
          end
        end
        up_w = 0;
      end
      if (dn) dn_w++;
      else if (dn_w > 0) begin
        dn_cnt++;
        if (dn_exp >= 0) begin
          tests++;
          if (dn_exp == 0 || dn_w < dn_exp - 1 || dn_w > dn_exp + 1) begin
            fails++;
            $display("FAIL dn_width: got %0d expected %0d (0 = no pulse)", dn_w, dn_exp);
          end
        end
        dn_w = 0;
      end
      if (err_valid) begin
        logic [CW+1:0] e, a;
        a = {lock, freq_err};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL window_result: got err_valid with freq_err %0d lock %0d, expected none",
                   $signed(freq_err), lock);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL window_result: got freq_err %0d lock %0d expected freq_err %0d lock %0d",
                     $signed(a[CW:0]), a[CW+1], $signed(e[CW:0]), e[CW+1]);
          end
        end
        if (have_prev) check("err_valid_period", cyc - prev_ev, WCYC);
        check("up_dn_exclusive", int'(both_seen), 0);
        check("lock_stable_between_windows", int'(lock_glitch), 0);
        both_seen = 1'b0; lock_glitch = 1'b0;
        prev_ev = cyc; have_prev = 1'b1;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int k;
    rst = 1'b1; ref_clk = 1'b0; fb = 1'b0;
    #1 rst = 1'b0;
    #1 check_all_zero("reset_initial");
    apply_reset();

    // Inputs held low after release: nothing may move.
    ref_en = 1'b0; fb_mode = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1);
      if (up || dn || lock || err_valid || freq_err != '0) begin
        check_all_zero("quiet");
        break;
      end
    end
    check("quiet_state", int'(pfd_state), 0);

    // Coincident edges: lock acquisition, no correction pulses.
    align();
    ref_en = 1'b1; fb_mode = 1; fb_lag = 0; up_exp = 0; dn_exp = 0;
    drive(5 * WCYC);
    check("lock_after_acquire", int'(lock), 1);

    // ref leads fb by 5.
    align();
    fb_lag = 5; up_exp = 5; dn_exp = 0; up_cnt = 0;
    drive(2 * WCYC);
    check("up_pulses_seen", int'(up_cnt >= 100), 1);

    // Asynchronous reset in the middle of an up pulse while locked.
    up_exp = -1;
    k = 0;
    while (!up && k < 40) begin drive(1); k++; end
    check("wait_up_high", int'(up), 1);
    check("lock_before_reset", int'(lock), int'(m_lock));
    #3 rst = 1'b0;
    #1 check_all_zero("reset_async");
    apply_reset();

    // fb leads ref by 5.
    align();
    fb_mode = 1; fb_lag = -5; up_exp = 0; dn_exp = 5; dn_cnt = 0;
    drive(2 * WCYC);
    check("dn_pulses_seen", int'(dn_cnt >= 100), 1);

    // Relock, then fb at double frequency.
    align();
    fb_lag = 0; up_exp = -1; dn_exp = -1;
    drive(5 * WCYC);
    check("lock_relock1", int'(lock), 1);
    align();
    fb_mode = 2; fb_per = 10;
    drive(2 * WCYC);
    check("lock_lost_fast_fb", int'(lock), 0);

    // Random extra fb pulses per window-length segment.
    align();
    fb_mode = 1; fb_lag = 0;
    drive(5 * WCYC);
    for (int s = 0; s < 4; s++) begin
      inj_left = int'($urandom_range(0, 3));
      drive(WCYC);
    end

    // Relock, then a window with exactly two extra fb edges.
    drive(5 * WCYC);
    check("lock_relock2", int'(lock), 1);
    inj_left = 2;
    drive(WCYC + RP);
    check("lock_after_plus2", int'(lock), 0);

    // fb saturating the counter, then fb stopped.
    align();
    fb_mode = 2; fb_per = 4;
    drive(3 * WCYC);
    check("sat_freq_err", int'($signed(freq_err)), (1 << CW) - 1 - WINDOW);
    fb_mode = 0;
    drive(3 * WCYC);
    check("starve_freq_err", int'($signed(freq_err)), -WINDOW);
    check("starve_lock", int'(lock), 0);

    ref_en = 1'b0;
    drive(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
